// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one external combinational ALU between two issue ports. A request is
//   accepted in IDLE, its operands are latched and presented to the ALU for one
//   EXEC cycle, and the ALU output is registered into that requester's response
//   slot, which is then offered until the requester takes it (RESP). Only one
//   operation is in flight, so each op takes at least three cycles. The block
//   also holds the architectural NZCV register, written by set-flags ops.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   reqN_valid/ready           request handshake (N = 0,1); ready is combinational
//   reqN_a/b/ctrl/setf         operands, ALU op, write-flags request
//   rspN_valid/ready           response handshake
//   rspN_result/flags/err      registered result, {N,Z,C,V}, illegal-op marker
//   alu_a/alu_b/alu_ctrl       registered operands/op to the shared ALU
//   alu_result/alu_flags       combinational ALU outputs
//   flags_q                    architectural NZCV register
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    input  logic             req0_setf,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    input  logic             req1_setf,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic [3:0]       rsp0_flags,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [3:0]       rsp1_flags,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic [3:0]       flags_q
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t state_q, state_d;

    // Requester-indexed views of the two issue/response ports.
    logic [1:0]            req_valid, req_ready, req_setf;
    logic [1:0][WIDTH-1:0] req_a, req_b;
    logic [1:0][2:0]       req_ctrl;
    logic [1:0]            rsp_valid, rsp_ready, rsp_err_q;
    logic [1:0][WIDTH-1:0] rsp_result_q;
    logic [1:0][3:0]       rsp_flags_q;

    assign req_valid = {req1_valid, req0_valid};
    assign req_setf  = {req1_setf,  req0_setf};
    assign req_a     = {req1_a,     req0_a};
    assign req_b     = {req1_b,     req0_b};
    assign req_ctrl  = {req1_ctrl,  req0_ctrl};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign rsp0_valid  = rsp_valid[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp0_result = rsp_result_q[0];
    assign rsp1_result = rsp_result_q[1];
    assign rsp0_flags  = rsp_flags_q[0];
    assign rsp1_flags  = rsp_flags_q[1];
    assign rsp0_err    = rsp_err_q[0];
    assign rsp1_err    = rsp_err_q[1];

    logic             grant_q, last_grant_q, sel;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       ctrl_q;
    logic             setf_q;
    logic             accept;
    logic             illegal;

    // The ALU sees the latched operands directly, so they stay put through EXEC
    // and keep showing the last op afterwards.
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctrl = ctrl_q;

    // 010 and 011 are the unused op encodings.
    assign illegal = (ctrl_q[2:1] == 2'b01);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        // Tie: round-robin away from the last served requester, or fixed
        // priority to requester 0. A single valid requester always wins.
        if (req_valid == 2'b11) sel = FAIR ? ~last_grant_q : 1'b0;
        else                    sel = req_valid[1];
        case (state_q)
            S_IDLE: begin
                // Gated by reset so no handshake is seen while reset is held.
                if (!reset && (|req_valid)) begin
                    req_ready[sel] = 1'b1;
                    accept         = 1'b1;
                    state_d        = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready[grant_q]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= '0;
            setf_q       <= 1'b0;
            flags_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= sel;
                a_q     <= req_a[sel];
                b_q     <= req_b[sel];
                ctrl_q  <= req_ctrl[sel];
                setf_q  <= req_setf[sel];
            end
            if (state_q == S_EXEC && !illegal && setf_q)
                flags_q <= alu_flags;
            if (state_q == S_RESP && rsp_ready[grant_q])
                last_grant_q <= grant_q;
        end
    end

    // Per-requester response slots: loaded at the end of EXEC for the granted
    // requester, otherwise held (including while the other side is served).
    for (genvar i = 0; i < 2; i++) begin : g_rsp
        assign rsp_valid[i] = (state_q == S_RESP) && (grant_q == 1'(i));

        always_ff @(posedge clk) begin
            if (reset) begin
                rsp_result_q[i] <= '0;
                rsp_flags_q[i]  <= '0;
                rsp_err_q[i]    <= 1'b0;
            end else if (state_q == S_EXEC && grant_q == 1'(i)) begin
                rsp_result_q[i] <= illegal ? '0 : alu_result;
                rsp_flags_q[i]  <= illegal ? 4'b0000 : alu_flags;
                rsp_err_q[i]    <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    localparam int W    = 32;
    localparam bit FAIR = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         req0_valid = 0, req1_valid = 0, req0_setf = 0, req1_setf = 0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0]   req0_ctrl = 0, req1_ctrl = 0;
    logic         rsp0_ready = 0, rsp1_ready = 0;
    logic         rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic [3:0]   rsp0_flags, rsp1_flags, flags_q;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_ctrl;
    logic [3:0]   alu_flags;

    alu_share_arbiter #(.WIDTH(W), .FAIR(FAIR)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .req0_setf(req0_setf),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .req1_setf(req1_setf),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags), .flags_q(flags_q)
    );

    // Attached ALU: {N,Z,C,V, result}; C is "no borrow" on SUB. Illegal ops
    // return junk so the arbiter must suppress it.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic cy, v;
        s = '0; r = '0; cy = 1'b0; v = 1'b0;
        case (c)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32];
                        v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cy = s[32];
                        v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            3'd7: r = a & ~b;
            default: return {4'b1111, a ^ 32'hDEADBEEF};
        endcase
        return {r[31], (r == 32'd0), cy, v, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_ctrl);

    int n_chk = 0, n_fail = 0;
    bit started = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // One op at a time: accepted -> ALU cycle -> offered until taken.
    bit          m_busy = 0, m_own = 0, m_last = 1, m_err = 0, m_wr = 0;
    int          m_cnt = 0;     // 1 = ALU cycle, 2 = response offered
    logic [31:0] m_res = 0, m_a = 0, m_b = 0;
    logic [3:0]  m_flg = 0, m_flags = 0;
    logic [2:0]  m_c = 0;

    function automatic bit pick(input bit v0, input bit v1);
        if (v0 && v1) return FAIR ? !m_last : 1'b0;
        return v1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 0; m_last <= 1; m_flags <= 0; m_a <= 0; m_b <= 0; m_c <= 0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                if (m_wr) m_flags <= m_flg;
                m_cnt <= 2;
            end else if (m_own ? rsp1_ready : rsp0_ready) begin
                m_busy <= 0;
                m_last <= m_own;
            end
        end else if (req0_valid || req1_valid) begin
            logic        g;
            logic [31:0] a, b;
            logic [2:0]  c;
            logic        sf;
            g  = pick(req0_valid, req1_valid);
            a  = g ? req1_a : req0_a;
            b  = g ? req1_b : req0_b;
            c  = g ? req1_ctrl : req0_ctrl;
            sf = g ? req1_setf : req0_setf;
            if (c == 3'b010 || c == 3'b011) begin
                m_res <= 0; m_flg <= 0; m_err <= 1; m_wr <= 0;
            end else begin
                {m_flg, m_res} <= alu_fn(a, b, c); m_err <= 0; m_wr <= sf;
            end
            m_a <= a; m_b <= b; m_c <= c;
            m_own <= g; m_busy <= 1; m_cnt <= 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [1:0] er, ev;
            er = 2'b00;
            if (!reset && !m_busy && (req0_valid || req1_valid))
                er = pick(req0_valid, req1_valid) ? 2'b10 : 2'b01;
            chk("req_ready", {30'd0, req1_ready, req0_ready}, {30'd0, er});
            ev = (m_busy && m_cnt == 2) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, {30'd0, ev});
            if (m_busy && m_cnt == 2) begin
                chk("rsp_result", m_own ? rsp1_result : rsp0_result, m_res);
                chk("rsp_flags", {28'd0, m_own ? rsp1_flags : rsp0_flags}, {28'd0, m_flg});
                chk("rsp_err", {31'd0, m_own ? rsp1_err : rsp0_err}, {31'd0, m_err});
            end
            chk("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, m_c});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present a request and hold it until accepted; returns in the ALU cycle.
    task automatic do_req(input bit n, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c, input bit sf);
        bit ok;
        ok = 0;
        if (!n) begin req0_a = a; req0_b = b; req0_ctrl = c; req0_setf = sf; req0_valid = 1; end
        else    begin req1_a = a; req1_b = b; req1_ctrl = c; req1_setf = sf; req1_valid = 1; end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (n ? req1_ready : req0_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("handshake", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        if (!n) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic consume(input bit n);
        if (!n) rsp0_ready = 1; else rsp1_ready = 1;
        tick();
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    initial begin
        bit seq[$];
        int when[$];
        tick(); started = 1;
        tick();
        // reset state
        chk("rst_rsp0_result", rsp0_result, 0);
        chk("rst_rsp1_flags", {28'd0, rsp1_flags}, 0);
        chk("rst_rsp_err", {30'd0, rsp1_err, rsp0_err}, 0);
        chk("rst_flags_q", {28'd0, flags_q}, 0);
        reset = 0;

        // T1: ADD overflow, setf; response two cycles after the handshake edge
        do_req(0, 32'h7FFFFFFF, 32'h1, 3'd0, 1);
        chk("t1_not_yet", {31'd0, rsp0_valid}, 0);
        tick();
        chk("t1_valid", {31'd0, rsp0_valid}, 1);
        chk("t1_result", rsp0_result, 32'h80000000);
        chk("t1_flags", {28'd0, rsp0_flags}, 32'h9);
        chk("t1_flags_q", {28'd0, flags_q}, 32'h9);
        consume(0);

        // T2: SUB borrow, no setf
        do_req(1, 32'h0, 32'h1, 3'd1, 0);
        tick();
        chk("t2_result", rsp1_result, 32'hFFFFFFFF);
        chk("t2_flags", {28'd0, rsp1_flags}, 32'h8);
        chk("t2_flags_q", {28'd0, flags_q}, 32'h9);
        consume(1);

        // T3: continuous tie after reset -> alternating grants, one per 3 cycles
        reset = 1; tick(); reset = 0;
        req0_a = 5; req0_b = 3; req0_ctrl = 3'd0; req0_setf = 0; req0_valid = 1;
        req1_a = 32'hF0; req1_b = 32'h3C; req1_ctrl = 3'd6; req1_setf = 0; req1_valid = 1;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (rsp0_valid) begin seq.push_back(0); when.push_back(i); end
            if (rsp1_valid) begin seq.push_back(1); when.push_back(i); end
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        chk("t3_count", seq.size(), 4);
        if (seq.size() == 4) begin
            chk("t3_order", {28'd0, seq[0], seq[1], seq[2], seq[3]}, 32'b0101);
            chk("t3_spacing", when[0] + 100 * (when[3] - when[0]), 2 + 100 * 9);
        end
        tick();

        // T4: backpressure on rsp0 while req1 waits
        do_req(0, 32'hFFFFFFFF, 32'h1, 3'd0, 1);
        req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = 3'd5; req1_setf = 0; req1_valid = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {31'd0, rsp0_valid}, 1);
            chk("t4_hold_result", rsp0_result, 32'h0);
            chk("t4_hold_flags", {28'd0, rsp0_flags}, 32'h6);
            chk("t4_req1_blocked", {31'd0, req1_ready}, 0);
            tick();
        end
        consume(0);
        do_req(1, 32'hF0, 32'h0F, 3'd5, 0);
        tick();
        chk("t4_rsp1_result", rsp1_result, 32'hFF);
        chk("t4_flags_q", {28'd0, flags_q}, 32'h6);
        consume(1);

        // T5: illegal op with setf
        do_req(0, 32'h1234, 32'h1, 3'b010, 1);
        tick();
        chk("t5_err", {31'd0, rsp0_err}, 1);
        chk("t5_result", rsp0_result, 0);
        chk("t5_flags", {28'd0, rsp0_flags}, 0);
        chk("t5_flags_q", {28'd0, flags_q}, 32'h6);
        consume(0);

        // T6: reset during the ALU cycle aborts the op; re-issue completes
        do_req(1, 32'hF0000000, 32'h80000001, 3'd4, 1);
        reset = 1; tick(); reset = 0;
        chk("t6_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 0);
        chk("t6_flags_q", {28'd0, flags_q}, 0);
        tick();
        chk("t6_still_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 0);
        do_req(1, 32'hF0000000, 32'h80000001, 3'd4, 1);
        tick();
        chk("t6_result", rsp1_result, 32'h80000000);
        chk("t6_flags", {28'd0, rsp1_flags}, 32'h8);
        chk("t6_flags_q2", {28'd0, flags_q}, 32'h8);
        consume(1);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
